// File: rtl/soc_pm_analog_config_pkg.sv
// Shared types for the pixel-matrix analog configuration shifter: word width, FSM states,
// field layout and the helper that packs the fields into the serial word.
package soc_pm_analog_config_pkg;

  localparam int PM_ANALOG_CONFIG_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LOAD     = 3'd3,
    ST_DONE     = 3'd4
  } state_t;

  // Member order equals chain order, MSB first.
  typedef struct packed {
    logic [37:0] res;
    logic [7:0]  th_high;
    logic [7:0]  th_low;
    logic [6:0]  ikrum;
    logic [6:0]  vblr;
    logic [5:0]  fed_csa;
    logic [5:0]  idiscr;
    logic [5:0]  ref_csa_in;
    logic [5:0]  ref_csa_mid;
    logic [5:0]  ref_csa_out;
    logic [5:0]  ref_dac;
    logic [5:0]  ref_dac_base;
    logic [5:0]  ref_dac_krum;
    logic [5:0]  shift_high;
    logic [5:0]  shift_low;
  } analog_config_t;

  function automatic logic [PM_ANALOG_CONFIG_W-1:0] pack_analog_config(input analog_config_t c);
    return {c.res, c.th_high, c.th_low, c.ikrum, c.vblr, c.fed_csa, c.idiscr,
            c.ref_csa_in, c.ref_csa_mid, c.ref_csa_out, c.ref_dac, c.ref_dac_base,
            c.ref_dac_krum, c.shift_high, c.shift_low};
  endfunction

endpackage

// File: rtl/soc_pm_analog_config_if.sv
// Analog bias/threshold field bundle from the SoC register block to the config shifter.
// Purely combinational field transport; no handshake.
interface soc_pm_analog_config;
  logic [37:0] res;
  logic [7:0]  th_high;
  logic [7:0]  th_low;
  logic [6:0]  ikrum;
  logic [6:0]  vblr;
  logic [5:0]  fed_csa;
  logic [5:0]  idiscr;
  logic [5:0]  ref_csa_in;
  logic [5:0]  ref_csa_mid;
  logic [5:0]  ref_csa_out;
  logic [5:0]  ref_dac;
  logic [5:0]  ref_dac_base;
  logic [5:0]  ref_dac_krum;
  logic [5:0]  shift_high;
  logic [5:0]  shift_low;

  modport master (output res, th_high, th_low, ikrum, vblr, fed_csa, idiscr, ref_csa_in,
                  ref_csa_mid, ref_csa_out, ref_dac, ref_dac_base, ref_dac_krum,
                  shift_high, shift_low);
  modport slave  (input  res, th_high, th_low, ikrum, vblr, fed_csa, idiscr, ref_csa_in,
                  ref_csa_mid, ref_csa_out, ref_dac, ref_dac_base, ref_dac_krum,
                  shift_high, shift_low);
endinterface

// File: rtl/soc_pm_cfg_sclk_tick.sv
// Serial-clock phase timer: tick is high in the last clk cycle of each CLK_DIV-long phase.
// Held at zero while restart is high, so every shift phase starts from a clean count.
module soc_pm_cfg_sclk_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || restart || tick) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/soc_pm_analog_config_shifter.sv
// Snapshots the analog config into a 128-bit word and shifts it MSB-first into the pixel chain, then strobes load;
// done lands 256*CLK_DIV+LOAD_WIDTH+1 cycles after start; start ignored while busy. Readback: SOC_PM_ANALOG_CONFIG_READBACK_EN.
module soc_pm_analog_config_shifter
  import soc_pm_analog_config_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned LOAD_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  soc_pm_analog_config.slave          analog_config,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        pm_cfg_sclk,
  output logic                        pm_cfg_sdata,
  output logic                        pm_cfg_load,
  input  logic                        pm_cfg_sdout,
  output logic                        readback_err
);

  localparam logic [3:0] LOAD_W = 4'(LOAD_WIDTH);

  state_t                        state;
  analog_config_t                cfg;
  logic [PM_ANALOG_CONFIG_W-1:0] cfg_word;
  logic [PM_ANALOG_CONFIG_W-1:0] snap;
  logic [6:0]                    bit_cnt;
  logic [3:0]                    load_cnt;
  logic                          tick;
  logic                          start_acc;
  logic                          load_end;
  logic                          shifting;

  always_comb begin
    cfg              = '0;
    cfg.res          = analog_config.res;
    cfg.th_high      = analog_config.th_high;
    cfg.th_low       = analog_config.th_low;
    cfg.ikrum        = analog_config.ikrum;
    cfg.vblr         = analog_config.vblr;
    cfg.fed_csa      = analog_config.fed_csa;
    cfg.idiscr       = analog_config.idiscr;
    cfg.ref_csa_in   = analog_config.ref_csa_in;
    cfg.ref_csa_mid  = analog_config.ref_csa_mid;
    cfg.ref_csa_out  = analog_config.ref_csa_out;
    cfg.ref_dac      = analog_config.ref_dac;
    cfg.ref_dac_base = analog_config.ref_dac_base;
    cfg.ref_dac_krum = analog_config.ref_dac_krum;
    cfg.shift_high   = analog_config.shift_high;
    cfg.shift_low    = analog_config.shift_low;
  end

  assign cfg_word  = pack_analog_config(cfg);
  assign start_acc = (state == ST_IDLE) && start;
  assign load_end  = (state == ST_LOAD) && (load_cnt == LOAD_W);
  assign shifting  = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);

  soc_pm_cfg_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (!shifting),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      snap         <= '0;
      bit_cnt      <= '0;
      load_cnt     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pm_cfg_sclk  <= 1'b0;
      pm_cfg_sdata <= 1'b0;
      pm_cfg_load  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start_acc) begin
            snap         <= cfg_word;
            bit_cnt      <= 7'd127;
            pm_cfg_sdata <= cfg_word[PM_ANALOG_CONFIG_W-1];
            pm_cfg_sclk  <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (tick) begin
            pm_cfg_sclk <= 1'b1;
            state       <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          // Data only moves on the falling sclk edge, giving the chain a full low phase of setup.
          if (tick) begin
            pm_cfg_sclk <= 1'b0;
            if (bit_cnt != 7'd0) begin
              bit_cnt      <= bit_cnt - 7'd1;
              pm_cfg_sdata <= snap[bit_cnt - 7'd1];
              state        <= ST_SHIFT_LO;
            end else begin
              pm_cfg_sdata <= 1'b0;
              load_cnt     <= 4'd0;
              state        <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          // Load rises one cycle after the last sclk fall so the chain sees a settled word.
          if (load_end) begin
            pm_cfg_load <= 1'b0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_DONE;
          end else begin
            pm_cfg_load <= 1'b1;
            load_cnt    <= load_cnt + 4'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SOC_PM_ANALOG_CONFIG_READBACK_EN
  logic [PM_ANALOG_CONFIG_W-1:0] cap;
  logic [PM_ANALOG_CONFIG_W-1:0] prev_snap;
  logic                          prev_valid;

  // The chain tail carries the word written by the previous transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap          <= '0;
      prev_snap    <= '0;
      prev_valid   <= 1'b0;
      readback_err <= 1'b0;
    end else begin
      if (start_acc) begin
        readback_err <= 1'b0;
      end
      if ((state == ST_SHIFT_LO) && tick) begin
        cap <= {cap[PM_ANALOG_CONFIG_W-2:0], pm_cfg_sdout};
      end
      if (load_end) begin
        readback_err <= prev_valid && (cap != prev_snap);
        prev_snap    <= snap;
        prev_valid   <= 1'b1;
      end
    end
  end
`else
  logic unused_sdout;
  assign unused_sdout = pm_cfg_sdout;
  assign readback_err = 1'b0;
`endif

endmodule

// File: tb/tb_soc_pm_analog_config_shifter.sv
// Scoreboard bench: stimulus queues expected serial bits / done cycles, a negedge monitor checks them.
module tb_soc_pm_analog_config_shifter;

  localparam int CLK_DIV    = 2;
  localparam int LOAD_WIDTH = 2;
  localparam int LAT        = 256 * CLK_DIV + LOAD_WIDTH + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, sclk, sdata, load, sdout, rb_err;

  soc_pm_analog_config cfg_if();

  soc_pm_analog_config_shifter #(.CLK_DIV(CLK_DIV), .LOAD_WIDTH(LOAD_WIDTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .analog_config (cfg_if),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .pm_cfg_sclk   (sclk),
    .pm_cfg_sdata  (sdata),
    .pm_cfg_load   (load),
    .pm_cfg_sdout  (sdout),
    .readback_err  (rb_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic exp_bits[$];
  int   exp_done[$];
  logic exp_rb[$];

  // Loopback chain model; flip_req corrupts one stored bit on the next shift.
  logic [127:0] chain = '0;
  logic flip_req = 1'b0;
  logic flip_used = 1'b0;
  assign sdout = chain[127];
  always @(posedge sclk) begin
    if (flip_req && !flip_used) begin
      chain     <= {chain[126:0], sdata} ^ (128'd1 << 64);
      flip_used <= 1'b1;
    end else begin
      chain <= {chain[126:0], sdata};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_fields();
    cfg_if.res = '0; cfg_if.th_high = '0; cfg_if.th_low = '0; cfg_if.ikrum = '0;
    cfg_if.vblr = '0; cfg_if.fed_csa = '0; cfg_if.idiscr = '0; cfg_if.ref_csa_in = '0;
    cfg_if.ref_csa_mid = '0; cfg_if.ref_csa_out = '0; cfg_if.ref_dac = '0;
    cfg_if.ref_dac_base = '0; cfg_if.ref_dac_krum = '0; cfg_if.shift_high = '0;
    cfg_if.shift_low = '0;
  endtask

  function automatic logic [127:0] model_word();
    return {cfg_if.res, cfg_if.th_high, cfg_if.th_low, cfg_if.ikrum, cfg_if.vblr,
            cfg_if.fed_csa, cfg_if.idiscr, cfg_if.ref_csa_in, cfg_if.ref_csa_mid,
            cfg_if.ref_csa_out, cfg_if.ref_dac, cfg_if.ref_dac_base, cfg_if.ref_dac_krum,
            cfg_if.shift_high, cfg_if.shift_low};
  endfunction

  task automatic start_txn(input logic [127:0] w, input logic rb);
    @(negedge clk);
    for (int i = 127; i >= 0; i--) exp_bits.push_back(w[i]);
    exp_done.push_back(cyc + 1 + LAT);
    exp_rb.push_back(rb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("rb_clear_on_start", 32'(rb_err), 32'd0);
  endtask

  task automatic wait_done();
    for (int n = 0; n < LAT + 200; n++) begin
      @(negedge clk);
      if (done) begin
        @(negedge clk);
        return;
      end
    end
    check("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_sclk"}, 32'(sclk), 32'd0);
    check({tag, "_sdata"}, 32'(sdata), 32'd0);
    check({tag, "_load"}, 32'(load), 32'd0);
    check({tag, "_rb_err"}, 32'(rb_err), 32'd0);
  endtask

  // Monitor: pops and compares whenever the DUT presents an sclk rise, load pulse or done.
  int   rises = 0;
  int   busy_run = 0;
  int   load_run = 0;
  logic sclk_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      rises = 0; busy_run = 0; load_run = 0; sclk_prev = 1'b0;
    end else begin
      if (sclk && !sclk_prev) begin
        rises++;
        if (exp_bits.size() == 0) check("unexpected_sclk_rise", 32'd1, 32'd0);
        else check("sdata_bit", 32'(sdata), 32'(exp_bits.pop_front()));
      end
      if (load) load_run++;
      else if (load_run != 0) begin
        check("load_width", load_run, LOAD_WIDTH);
        load_run = 0;
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", 32'd1, 32'd0);
        else begin
          check("done_cycle", cyc, exp_done.pop_front());
          check("rb_err_at_done", 32'(rb_err), 32'(exp_rb.pop_front()));
        end
        check("sclk_rises", rises, 128);
        check("busy_span", busy_run, LAT);
        check("busy_low_in_done", 32'(busy), 32'd0);
        rises = 0;
        busy_run = 0;
      end
      if (busy) busy_run++;
      sclk_prev = sclk;
    end
  end

  initial begin
    logic [127:0] w;
    clear_fields();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // res alternating pattern: first 38 sampled bits 1,0,1,0..., rest 0.
    cfg_if.res = 38'h2A_AAAA_AAAA;
    w = '0;
    for (int i = 0; i < 38; i++) w[127 - i] = ((i % 2) == 0);
    start_txn(w, 1'b0);
    wait_done();

    // th_high only: sampled bits 38..45 set.
    clear_fields();
    cfg_if.th_high = 8'hFF;
    w = '0;
    for (int i = 38; i <= 45; i++) w[127 - i] = 1'b1;
    start_txn(w, 1'b0);
    wait_done();

    // Extra starts mid-transaction must be ignored.
    clear_fields();
    cfg_if.res = 38'h12_3456_7890; cfg_if.th_low = 8'hC3; cfg_if.ikrum = 7'h5A;
    cfg_if.fed_csa = 6'h15; cfg_if.ref_dac = 6'h2E; cfg_if.shift_low = 6'h3F;
    start_txn(model_word(), 1'b0);
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (289) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // Field change mid-transaction: old snapshot shifted, new values next time.
    clear_fields();
    cfg_if.vblr = 7'h7F; cfg_if.idiscr = 6'h21; cfg_if.shift_high = 6'h0C;
    start_txn(model_word(), 1'b0);
    repeat (49) @(negedge clk);
    cfg_if.vblr = 7'h01; cfg_if.ref_csa_mid = 6'h33; cfg_if.ref_dac_krum = 6'h11;
    cfg_if.th_high = 8'h81;
    wait_done();
    start_txn(model_word(), 1'b0);
    wait_done();

    // Reset mid-transaction.
    cfg_if.ref_csa_in = 6'h2A; cfg_if.ref_dac_base = 6'h15;
    start_txn(model_word(), 1'b0);
    repeat (198) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    exp_bits.delete();
    void'(exp_done.pop_back());
    void'(exp_rb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    start_txn(model_word(), 1'b0);
    wait_done();

`ifdef SOC_PM_ANALOG_CONFIG_READBACK_EN
    clear_fields();
    cfg_if.res = 38'h3F_0F0F_0F0F; cfg_if.ref_csa_out = 6'h19;
    start_txn(model_word(), 1'b0);
    wait_done();
    clear_fields();
    cfg_if.th_low = 8'h5A; cfg_if.ikrum = 7'h33;
    start_txn(model_word(), 1'b0);
    wait_done();
    flip_req = 1'b1;
    clear_fields();
    cfg_if.shift_high = 6'h2D;
    start_txn(model_word(), 1'b1);
    wait_done();
    cfg_if.fed_csa = 6'h07;
    start_txn(model_word(), 1'b0);
    wait_done();
`endif

    repeat (10) @(negedge clk);
    check("leftover_bits", exp_bits.size(), 0);
    check("leftover_done", exp_done.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
